// File: rtl/ob_sorted_table.sv
// Price-time-priority order table for one book side; entry 0 is always the best order.
// Optional OB_SORTED_TABLE_CANCEL_EN enables cancel-by-ID; without it CANCEL only answers miss.
module ob_sorted_table #(
    parameter int N       = 16,
    parameter int PRICE_W = 16,
    parameter int QTY_W   = 16,
    parameter int UID_W   = 32,
    parameter bit IS_ASK  = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     cmd_vld_i,
    output logic                     cmd_rdy_o,
    input  logic [1:0]               cmd_op_i,
    input  logic [UID_W-1:0]         cmd_uid_i,
    input  logic [PRICE_W-1:0]       cmd_price_i,
    input  logic [QTY_W-1:0]         cmd_qty_i,
    output logic                     head_vld_o,
    output logic [UID_W-1:0]         head_uid_o,
    output logic [PRICE_W-1:0]       head_price_o,
    output logic [QTY_W-1:0]         head_qty_o,
    output logic [$clog2(N+1)-1:0]   count_o,
    output logic                     rsp_vld_o,
    output logic                     rsp_hit_o,
    output logic                     reject_vld_o,
    output logic [UID_W-1:0]         reject_uid_o,
    output logic [PRICE_W-1:0]       reject_price_o,
    output logic [QTY_W-1:0]         reject_qty_o,
    input  logic                     reject_pop_i
);

    localparam int CW = $clog2(N+1);

    localparam logic [1:0] OP_INSTALL = 2'd0;
    localparam logic [1:0] OP_POP     = 2'd1;
    localparam logic [1:0] OP_FILL    = 2'd2;
    localparam logic [1:0] OP_CANCEL  = 2'd3;

    logic               vld_q   [N];
    logic [UID_W-1:0]   uid_q   [N];
    logic [PRICE_W-1:0] price_q [N];
    logic [QTY_W-1:0]   qty_q   [N];
    logic               vld_d   [N];
    logic [UID_W-1:0]   uid_d   [N];
    logic [PRICE_W-1:0] price_d [N];
    logic [QTY_W-1:0]   qty_d   [N];

    logic [CW-1:0]      count_q, count_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic               rej_vld_q, rej_vld_d;
    logic [UID_W-1:0]   rej_uid_q, rej_uid_d;
    logic [PRICE_W-1:0] rej_price_q, rej_price_d;
    logic [QTY_W-1:0]   rej_qty_q, rej_qty_d;

    logic               accept;
    logic               full;
    logic               rej_free;
    logic               ins_found;
    int                 ins_idx;
    logic               do_remove;
    int                 rm_idx;
    logic [QTY_W:0]     fill_diff;
`ifdef OB_SORTED_TABLE_CANCEL_EN
    logic               cxl_found;
    int                 cxl_idx;
`endif

    function automatic logic better(input logic [PRICE_W-1:0] a, input logic [PRICE_W-1:0] b);
        return IS_ASK ? (a < b) : (a > b);
    endfunction

    // Conservative stall: only registers feed ready, never cmd_vld_i.
    assign cmd_rdy_o = !(rej_vld_q && (count_q == CW'(N)));
    assign accept    = cmd_vld_i && cmd_rdy_o;
    assign full      = vld_q[N-1];
    assign rej_free  = !rej_vld_q || reject_pop_i;
    assign fill_diff = {1'b0, qty_q[0]} - {1'b0, cmd_qty_i};

    always_comb begin
        for (int i = 0; i < N; i++) begin
            vld_d[i]   = vld_q[i];
            uid_d[i]   = uid_q[i];
            price_d[i] = price_q[i];
            qty_d[i]   = qty_q[i];
        end
        count_d     = count_q;
        rsp_vld_d   = 1'b0;
        rsp_hit_d   = 1'b0;
        rej_vld_d   = reject_pop_i ? 1'b0 : rej_vld_q;
        rej_uid_d   = rej_uid_q;
        rej_price_d = rej_price_q;
        rej_qty_d   = rej_qty_q;
        do_remove   = 1'b0;
        rm_idx      = 0;

        // First slot that is empty or holds a strictly worse price; ties stay ahead.
        ins_found = 1'b0;
        ins_idx   = N;
        for (int i = 0; i < N; i++) begin
            if (!ins_found && (!vld_q[i] || better(cmd_price_i, price_q[i]))) begin
                ins_found = 1'b1;
                ins_idx   = i;
            end
        end

`ifdef OB_SORTED_TABLE_CANCEL_EN
        cxl_found = 1'b0;
        cxl_idx   = 0;
        for (int i = 0; i < N; i++) begin
            if (!cxl_found && vld_q[i] && (uid_q[i] == cmd_uid_i)) begin
                cxl_found = 1'b1;
                cxl_idx   = i;
            end
        end
`endif

        if (accept) begin
            case (cmd_op_i)
                OP_INSTALL: begin
                    if (ins_found) begin
                        if (full) begin
                            if (rej_free) begin
                                rej_vld_d   = 1'b1;
                                rej_uid_d   = uid_q[N-1];
                                rej_price_d = price_q[N-1];
                                rej_qty_d   = qty_q[N-1];
                            end
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                        for (int i = N-1; i > 0; i--) begin
                            if (i > ins_idx) begin
                                vld_d[i]   = vld_q[i-1];
                                uid_d[i]   = uid_q[i-1];
                                price_d[i] = price_q[i-1];
                                qty_d[i]   = qty_q[i-1];
                            end
                        end
                        for (int i = 0; i < N; i++) begin
                            if (i == ins_idx) begin
                                vld_d[i]   = 1'b1;
                                uid_d[i]   = cmd_uid_i;
                                price_d[i] = cmd_price_i;
                                qty_d[i]   = cmd_qty_i;
                            end
                        end
                    end else if (rej_free) begin
                        rej_vld_d   = 1'b1;
                        rej_uid_d   = cmd_uid_i;
                        rej_price_d = cmd_price_i;
                        rej_qty_d   = cmd_qty_i;
                    end
                end
                OP_POP: begin
                    do_remove = vld_q[0];
                end
                OP_FILL: begin
                    if (vld_q[0]) begin
                        // Borrow bit set or zero remainder means the head is used up.
                        if (fill_diff[QTY_W] || (fill_diff[QTY_W-1:0] == '0)) begin
                            do_remove = 1'b1;
                        end else begin
                            qty_d[0] = fill_diff[QTY_W-1:0];
                        end
                    end
                end
                default: begin
                    rsp_vld_d = 1'b1;
`ifdef OB_SORTED_TABLE_CANCEL_EN
                    rsp_hit_d = cxl_found;
                    do_remove = cxl_found;
                    rm_idx    = cxl_idx;
`endif
                end
            endcase
        end

        if (do_remove) begin
            for (int i = 0; i < N-1; i++) begin
                if (i >= rm_idx) begin
                    vld_d[i]   = vld_q[i+1];
                    uid_d[i]   = uid_q[i+1];
                    price_d[i] = price_q[i+1];
                    qty_d[i]   = qty_q[i+1];
                end
            end
            vld_d[N-1]   = 1'b0;
            uid_d[N-1]   = '0;
            price_d[N-1] = '0;
            qty_d[N-1]   = '0;
            count_d      = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < N; i++) begin
                vld_q[i]   <= 1'b0;
                uid_q[i]   <= '0;
                price_q[i] <= '0;
                qty_q[i]   <= '0;
            end
            count_q     <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rej_vld_q   <= 1'b0;
            rej_uid_q   <= '0;
            rej_price_q <= '0;
            rej_qty_q   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                vld_q[i]   <= vld_d[i];
                uid_q[i]   <= uid_d[i];
                price_q[i] <= price_d[i];
                qty_q[i]   <= qty_d[i];
            end
            count_q     <= count_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_hit_q   <= rsp_hit_d;
            rej_vld_q   <= rej_vld_d;
            rej_uid_q   <= rej_uid_d;
            rej_price_q <= rej_price_d;
            rej_qty_q   <= rej_qty_d;
        end
    end

    assign head_vld_o     = vld_q[0];
    assign head_uid_o     = uid_q[0];
    assign head_price_o   = price_q[0];
    assign head_qty_o     = qty_q[0];
    assign count_o        = count_q;
    assign rsp_vld_o      = rsp_vld_q;
    assign rsp_hit_o      = rsp_hit_q;
    assign reject_vld_o   = rej_vld_q;
    assign reject_uid_o   = rej_uid_q;
    assign reject_price_o = rej_price_q;
    assign reject_qty_o   = rej_qty_q;

endmodule

// File: tb/tb_ob_sorted_table.sv
// Bench for ob_sorted_table: an ask and a bid instance (N=4) share one command stream
// and are compared every cycle against a queue-based model of the order table.
module tb_ob_sorted_table;

    localparam int N = 4;
`ifdef OB_SORTED_TABLE_CANCEL_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    localparam logic [1:0] INSTALL = 2'd0;
    localparam logic [1:0] POP     = 2'd1;
    localparam logic [1:0] FILL    = 2'd2;
    localparam logic [1:0] CANCEL  = 2'd3;

    typedef struct packed {
        logic [31:0] uid;
        logic [15:0] price;
        logic [15:0] qty;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_vld;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_uid;
    logic [15:0] cmd_price;
    logic [15:0] cmd_qty;
    logic        reject_pop;

    logic [1:0]  rdy_w, hvld_w, rspv_w, rsph_w, rejv_w;
    logic [31:0] huid_w [2];
    logic [15:0] hprice_w [2];
    logic [15:0] hqty_w [2];
    logic [2:0]  cnt_w [2];
    logic [31:0] ruid_w [2];
    logic [15:0] rprice_w [2];
    logic [15:0] rqty_w [2];

    // Model state, index 0 = ask, 1 = bid; n* holds the value after the coming edge.
    ent_t tq [2][$];
    ent_t nq [2][$];
    ent_t rej [2], nrej [2];
    bit   rejv [2], nrejv [2];
    bit   rspv [2], nrspv [2];
    bit   rsph [2], nrsph [2];

    int  n_cmp = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    ob_sorted_table #(.N(N), .IS_ASK(1'b1)) u_ask (
        .clk_i(clk), .rst_n_i(rst_n), .cmd_vld_i(cmd_vld), .cmd_rdy_o(rdy_w[0]),
        .cmd_op_i(cmd_op), .cmd_uid_i(cmd_uid), .cmd_price_i(cmd_price), .cmd_qty_i(cmd_qty),
        .head_vld_o(hvld_w[0]), .head_uid_o(huid_w[0]), .head_price_o(hprice_w[0]),
        .head_qty_o(hqty_w[0]), .count_o(cnt_w[0]), .rsp_vld_o(rspv_w[0]), .rsp_hit_o(rsph_w[0]),
        .reject_vld_o(rejv_w[0]), .reject_uid_o(ruid_w[0]), .reject_price_o(rprice_w[0]),
        .reject_qty_o(rqty_w[0]), .reject_pop_i(reject_pop)
    );

    ob_sorted_table #(.N(N), .IS_ASK(1'b0)) u_bid (
        .clk_i(clk), .rst_n_i(rst_n), .cmd_vld_i(cmd_vld), .cmd_rdy_o(rdy_w[1]),
        .cmd_op_i(cmd_op), .cmd_uid_i(cmd_uid), .cmd_price_i(cmd_price), .cmd_qty_i(cmd_qty),
        .head_vld_o(hvld_w[1]), .head_uid_o(huid_w[1]), .head_price_o(hprice_w[1]),
        .head_qty_o(hqty_w[1]), .count_o(cnt_w[1]), .rsp_vld_o(rspv_w[1]), .rsp_hit_o(rsph_w[1]),
        .reject_vld_o(rejv_w[1]), .reject_uid_o(ruid_w[1]), .reject_price_o(rprice_w[1]),
        .reject_qty_o(rqty_w[1]), .reject_pop_i(reject_pop)
    );

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%s] t=%0t: got %0d, expected %0d", nm, d == 0 ? "ask" : "bid", $time, act, exp);
        end
    endtask

    function automatic bit better(input int d, input logic [15:0] a, input logic [15:0] b);
        return (d == 0) ? (a < b) : (a > b);
    endfunction

    function automatic void model_step(input int d);
        ent_t q[$];
        ent_t r;
        ent_t e;
        bit   rv, acc, sv, sh, found;
        int   pos;
        q  = tq[d];
        r  = rej[d];
        rv = rejv[d];
        sv = 1'b0;
        sh = 1'b0;
        if (!rst_n) begin
            q.delete();
            r  = '0;
            rv = 1'b0;
        end else begin
            acc = cmd_vld && !(rv && q.size() == N);
            if (reject_pop) rv = 1'b0;
            if (acc) begin
                case (cmd_op)
                    INSTALL: begin
                        e.uid = cmd_uid; e.price = cmd_price; e.qty = cmd_qty;
                        pos = q.size();
                        found = 1'b0;
                        for (int i = 0; i < q.size(); i++)
                            if (!found && better(d, e.price, q[i].price)) begin
                                pos = i;
                                found = 1'b1;
                            end
                        if (q.size() < N) q.insert(pos, e);
                        else if (pos < N) begin
                            r = q[N-1]; rv = 1'b1;
                            q.delete(N-1);
                            q.insert(pos, e);
                        end else begin
                            r = e; rv = 1'b1;
                        end
                    end
                    POP: if (q.size() > 0) void'(q.pop_front());
                    FILL: if (q.size() > 0) begin
                        if (cmd_qty >= q[0].qty) void'(q.pop_front());
                        else begin
                            e = q[0];
                            e.qty = e.qty - cmd_qty;
                            q[0] = e;
                        end
                    end
                    default: begin
                        sv = 1'b1;
                        found = 1'b0;
                        if (CANCEL_EN)
                            for (int i = 0; i < q.size(); i++)
                                if (!found && q[i].uid == cmd_uid) begin
                                    pos = i;
                                    found = 1'b1;
                                end
                        if (found) begin
                            q.delete(pos);
                            sh = 1'b1;
                        end
                    end
                endcase
            end
        end
        nq[d]    = q;
        nrej[d]  = r;
        nrejv[d] = rv;
        nrspv[d] = sv;
        nrsph[d] = sh;
    endfunction

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            tq[d]   = nq[d];
            rej[d]  = nrej[d];
            rejv[d] = nrejv[d];
            rspv[d] = nrspv[d];
            rsph[d] = nrsph[d];
        end
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [31:0] uid, input logic [15:0] price,
                       input logic [15:0] qty);
        cmd_vld = 1'b1; cmd_op = op; cmd_uid = uid; cmd_price = price; cmd_qty = qty;
        tick();
        cmd_vld = 1'b0;
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                ent_t h;
                h = (tq[d].size() > 0) ? tq[d][0] : '0;
                chk("cmd_rdy", d, rdy_w[d], !(rejv[d] && tq[d].size() == N));
                chk("head_vld", d, hvld_w[d], tq[d].size() > 0);
                chk("head_uid", d, huid_w[d], h.uid);
                chk("head_price", d, hprice_w[d], h.price);
                chk("head_qty", d, hqty_w[d], h.qty);
                chk("count", d, cnt_w[d], tq[d].size());
                chk("rsp_vld", d, rspv_w[d], rspv[d]);
                chk("rsp_hit", d, rsph_w[d], rsph[d]);
                chk("reject_vld", d, rejv_w[d], rejv[d]);
                chk("reject_uid", d, ruid_w[d], rej[d].uid);
                chk("reject_price", d, rprice_w[d], rej[d].price);
                chk("reject_qty", d, rqty_w[d], rej[d].qty);
            end
        end
    end

    initial begin
        rst_n = 1'b0; cmd_vld = 1'b0; cmd_op = '0; cmd_uid = '0; cmd_price = '0; cmd_qty = '0;
        reject_pop = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rej[d] = '0; rejv[d] = 1'b0; rspv[d] = 1'b0; rsph[d] = 1'b0;
        end
        tick(); tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("lit_reset_count", 0, cnt_w[0], 0);
        chk("lit_reset_rdy", 1, rdy_w[1], 1);

        // Ask: 40(7),40(9),50(1),60(3); bid: 60(3),50(1),40(7),40(9).
        cmd(INSTALL, 1, 50, 10);
        cmd(INSTALL, 7, 40, 10);
        cmd(INSTALL, 3, 60, 10);
        cmd(INSTALL, 9, 40, 10);
        chk("lit_ask_head_uid", 0, huid_w[0], 7);
        chk("lit_ask_head_price", 0, hprice_w[0], 40);
        chk("lit_ask_count", 0, cnt_w[0], 4);
        chk("lit_bid_head_uid", 1, huid_w[1], 3);
        cmd(POP, 0, 0, 0);
        chk("lit_ask_tie_order", 0, huid_w[0], 9);
        chk("lit_bid_after_pop", 1, huid_w[1], 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;

        // Full-table eviction and reject-slot stall.
        cmd(INSTALL, 11, 100, 1);
        cmd(INSTALL, 12, 90, 1);
        cmd(INSTALL, 13, 80, 1);
        cmd(INSTALL, 14, 70, 1);
        cmd(INSTALL, 15, 85, 1);
        chk("lit_bid_evict_uid", 1, ruid_w[1], 14);
        chk("lit_bid_evict_price", 1, rprice_w[1], 70);
        chk("lit_bid_stall", 1, rdy_w[1], 0);
        chk("lit_ask_evict_uid", 0, ruid_w[0], 11);
        cmd_vld = 1'b1; cmd_op = INSTALL; cmd_uid = 16; cmd_price = 60; cmd_qty = 2;
        tick(); tick();
        chk("lit_bid_stalled_count", 1, cnt_w[1], 4);
        chk("lit_bid_stalled_rej", 1, ruid_w[1], 14);
        reject_pop = 1'b1;
        tick();
        reject_pop = 1'b0;
        chk("lit_bid_rdy_after_pop", 1, rdy_w[1], 1);
        tick();
        cmd_vld = 1'b0;
        chk("lit_bid_reject_new", 1, ruid_w[1], 16);
        chk("lit_bid_head_price", 1, hprice_w[1], 100);
        chk("lit_ask_head_price", 0, hprice_w[0], 60);
        chk("lit_ask_evict2_uid", 0, ruid_w[0], 12);

        // Reset with a full table and a pending reject, command still presented.
        rst_n = 1'b0; cmd_vld = 1'b1;
        tick();
        rst_n = 1'b1; cmd_vld = 1'b0;
        chk("lit_rst_rdy", 0, rdy_w[0], 1);
        chk("lit_rst_rejv", 1, rejv_w[1], 0);
        chk("lit_rst_rej_uid", 1, ruid_w[1], 0);
        chk("lit_rst_head_uid", 0, huid_w[0], 0);

        // Partial and complete fills, then POP/FILL on an empty table.
        cmd(INSTALL, 21, 50, 10);
        cmd(INSTALL, 22, 50, 5);
        cmd(FILL, 0, 0, 4);
        chk("lit_fill_qty", 0, hqty_w[0], 6);
        chk("lit_fill_uid", 1, huid_w[1], 21);
        cmd(FILL, 0, 0, 6);
        chk("lit_fill_exact_uid", 0, huid_w[0], 22);
        chk("lit_fill_exact_count", 1, cnt_w[1], 1);
        cmd(FILL, 0, 0, 9);
        chk("lit_fill_over_count", 0, cnt_w[0], 0);
        cmd(POP, 0, 0, 0);
        cmd(FILL, 0, 0, 3);
        chk("lit_empty_hvld", 0, hvld_w[0], 0);
        chk("lit_empty_count", 1, cnt_w[1], 0);

        // Cancel the middle entry, then an absent ID.
        cmd(INSTALL, 31, 30, 1);
        cmd(INSTALL, 32, 20, 1);
        cmd(INSTALL, 33, 10, 1);
        cmd(CANCEL, 32, 0, 0);
        chk("lit_cxl_rsp", 0, rspv_w[0], 1);
        chk("lit_cxl_hit", 0, rsph_w[0], CANCEL_EN);
        chk("lit_cxl_count", 1, cnt_w[1], CANCEL_EN ? 2 : 3);
        cmd(POP, 0, 0, 0);
        chk("lit_cxl_order", 0, huid_w[0], CANCEL_EN ? 31 : 32);
        cmd(CANCEL, 99, 0, 0);
        chk("lit_miss_rsp", 1, rspv_w[1], 1);
        chk("lit_miss_hit", 1, rsph_w[1], 0);
        tick();
        chk("lit_rsp_pulse", 0, rspv_w[0], 0);

        // Pop of an empty reject slot is ignored.
        reject_pop = 1'b1;
        tick();
        reject_pop = 1'b0;
        tick();
        chk("lit_final_count", 0, cnt_w[0], CANCEL_EN ? 1 : 2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ob_sorted_table.md
# ob_sorted_table

Parametrised, price-time-priority order table for one side of the order book: a shift-register array of N entries kept sorted so entry 0 is always the best order. Generalises the single-side table with configurable widths/depth, head partial fills, cancel-by-ID, and eviction of the worst resting order to a one-deep reject slot when full. Sits between the command decoder and the matching engine, which consumes `head_r`.

## Interface
- `N`, 16: table depth, ≥2.
- `PRICE_W`, 16: price width, unsigned.
- `QTY_W`, 16: quantity width, unsigned.
- `UID_W`, 32: order ID width.
- `IS_ASK`, 1: 1 means best is lowest price; 0 means best is highest price.
- `clk` in 1: clock; one clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_vld` in 1: command valid.
- `cmd_rdy` out 1: command accepted when `cmd_vld && cmd_rdy`.
- `cmd_op` in 2: 0 INSTALL, 1 POP, 2 FILL, 3 CANCEL.
- `cmd_uid` in UID_W: INSTALL/CANCEL ID.
- `cmd_price` in PRICE_W: INSTALL price.
- `cmd_qty` in QTY_W: INSTALL qty or FILL amount.
- `head_vld_r` out 1: entry 0 valid.
- `head_uid_r`, `head_price_r`, `head_qty_r` out UID_W/PRICE_W/QTY_W: entry 0 contents.
- `count_r` out $clog2(N+1): number of valid entries.
- `rsp_vld_r` out 1: one-cycle pulse, one cycle after each accepted CANCEL.
- `rsp_hit_r` out 1: CANCEL found its ID.
- `reject_vld_r` out 1: reject slot occupied.
- `reject_uid_r`, `reject_price_r`, `reject_qty_r` out: rejected or evicted order.
- `reject_pop` in 1: frees the reject slot.

## Operation
- Storage: entries 0..N-1, each valid/uid/price/qty. Valid entries are contiguous from 0 and strictly ordered by price priority. Equal prices are kept in arrival order, so the newer order sits behind.
- "Better" means price < for ask and price > for bid. Tie is not better.
- INSTALL, not full: insert at the first index whose entry is invalid or strictly worse than the new price. Entries at and after that index shift down by one.
- INSTALL, full: compare against entry N-1.
  - New order better: insert as above; the old entry N-1 moves to the reject slot.
  - Otherwise: the new order goes to the reject slot and the table is unchanged.
- POP: remove entry 0 and shift all entries up. POP on an empty table is a no-op.
- FILL: `head_qty -= cmd_qty`. If the result is ≤0, computed at QTY_W+1 bits, the head is removed as for POP. FILL on an empty table is a no-op.
- CANCEL: find the lowest matching valid uid and remove it, compacting entries up. Response is hit=1; if no match, the table is unchanged and hit=0.
- `cmd_rdy = !(reject_vld_r && count_r==N)`. This is a conservative stall; it is set even for non-INSTALL ops.
- Reject slot: written only when empty, or when `reject_pop` is asserted in the same cycle (pop-then-write). `reject_pop` while empty is ignored.
- Duplicate uid on INSTALL is not checked; CANCEL removes the first match.

## Timing
- One command per cycle. Table, head, and count update on the edge after acceptance, so head is visible 1 cycle later.
- `reject_vld_r` rises 1 cycle after the causing INSTALL and falls 1 cycle after `reject_pop`.
- `rsp_vld_r`/`rsp_hit_r` are valid 1 cycle after CANCEL acceptance, for exactly 1 cycle.
- `cmd_rdy` is combinational from registers only, with no path from `cmd_vld`.
- Reset while `rst_n`=0 at an edge:
  - all entry valids = 0, `head_vld_r`=0, `count_r`=0, `reject_vld_r`=0, `rsp_vld_r`=0, `rsp_hit_r`=0;
  - head and reject data = 0, so `cmd_rdy`=1 after reset.
  - Reset mid-operation discards the table and the pending reject with no response.

## Configuration
- `OB_SORTED_TABLE_CANCEL_EN` defined: CANCEL is implemented as above, including the N-way uid compare.
- Not defined: the compare logic is omitted; CANCEL is accepted, the table is unchanged, `rsp_vld_r` pulses with `rsp_hit_r`=0.

## Test plan
- Ask, N=4, INSTALL prices 50,40,60,40(uid 7 then 9) -> prices 40(7),40(9),50,60; head uid 7; count 4.
- Bid, N=4, full {100,90,80,70}, INSTALL 85:
  - 70 goes to reject; table becomes 100,90,85,80.
  - Then INSTALL 60 with reject full -> `cmd_rdy`=0 until `reject_pop`; after pop, 60 is rejected.
- Head qty 10: FILL 4 -> qty 6, head unchanged. FILL 6 -> head removed, next entry becomes head; count decrements.
- CANCEL the middle uid of 3 entries -> hit=1 one cycle later, remaining two entries keep their order. CANCEL an absent uid -> hit=0. With the macro undefined -> hit=0 always.
- POP and FILL on an empty table -> no change, `head_vld_r`=0, `count_r`=0.
- Assert `rst_n`=0 with 3 entries and a pending reject -> next cycle every output is 0 and `cmd_rdy`=1.
